// File: rtl/fifo_rd_prefetch_if.sv
//------------------------------------------------------------------------------
// fifo_rd_prefetch_if : FIFO read-side and downstream valid/ready bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_rd_prefetch_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  rinc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // master: the prefetch block; slave: FIFO pointer/memory plus consumer
  modport master (
    input  rempty,
    input  r_data,
    output rinc,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport slave (
    output rempty,
    output r_data,
    input  rinc,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_prefetch.sv
//------------------------------------------------------------------------------
// fifo_rd_prefetch : 2-entry prefetch buffer draining an async FIFO read side
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_rd_prefetch #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                 r_clk,
  input  wire logic                 rrst_n,
  fifo_rd_prefetch_if.master        bus,
  input  wire logic                 flush,
  output logic [1:0]                buf_cnt,
  output logic [CNT_WIDTH-1:0]      xfer_cnt
);

  localparam logic [1:0] C_EMPTY = 2'd0;
  localparam logic [1:0] C_ONE   = 2'd1;
  localparam logic [1:0] C_FULL  = 2'd2;

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic [1:0]            cnt;
  logic                  push;
  logic                  pop;

  // rinc sees only registered cnt plus rempty/flush, never out_ready
  assign push = !bus.rempty && (cnt != C_FULL) && !flush;
  assign pop  = (cnt != C_EMPTY) && !flush && bus.out_ready;

  assign bus.rinc      = push;
  assign bus.out_valid = (cnt != C_EMPTY) && !flush;
  assign bus.out_data  = slot0;
  assign buf_cnt       = cnt;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt   <= C_EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      cnt <= C_EMPTY;
    end else begin
      case (cnt)
        C_EMPTY: begin
          if (push) begin
            slot0 <= bus.r_data;
            cnt   <= C_ONE;
          end
        end
        C_ONE: begin
          if (push && pop) begin
            slot0 <= bus.r_data;
          end else if (push) begin
            slot1 <= bus.r_data;
            cnt   <= C_FULL;
          end else if (pop) begin
            cnt <= C_EMPTY;
          end
        end
        C_FULL: begin
          if (pop) begin
            slot0 <= slot1;
            cnt   <= C_ONE;
          end
        end
        default: cnt <= C_EMPTY;
      endcase
    end
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_prefetch.sv
//------------------------------------------------------------------------------
// tb_fifo_rd_prefetch : directed + random bench against a queue-based model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_rd_prefetch;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          r_clk  = 1'b0;
  logic          rrst_n = 1'b1;
  logic          flush  = 1'b0;
  logic [1:0]    buf_cnt;
  logic [CW-1:0] xfer_cnt;

  fifo_rd_prefetch_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_prefetch #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .r_clk    (r_clk),
    .rrst_n   (rrst_n),
    .bus      (bus),
    .flush    (flush),
    .buf_cnt  (buf_cnt),
    .xfer_cnt (xfer_cnt)
  );

  always #5 r_clk = ~r_clk;

  int total = 0;
  int bad   = 0;
  int rinc_seen = 0;
  int unsigned mxfer = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] mbuf[$];
  logic [DW-1:0] delivered[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.rempty = (fifo_q.size() == 0);
    bus.r_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One cycle: drive, check against model, clock, advance model.
  task automatic step(input logic ready, input logic fl);
    logic e_rinc, e_valid;
    bus.out_ready = ready;
    flush = fl;
    drive_fifo();
    #1;
    e_rinc  = (fifo_q.size() != 0) && (mbuf.size() < 2) && !fl;
    e_valid = (mbuf.size() != 0) && !fl;
    chk("rinc", 32'(bus.rinc), 32'(e_rinc));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    if (mbuf.size() != 0) chk("out_data", 32'(bus.out_data), 32'(mbuf[0]));
    chk("buf_cnt", 32'(buf_cnt), 32'(mbuf.size()));
    chk("xfer_cnt", 32'(xfer_cnt), mxfer % (1 << CW));
    if (bus.rinc) rinc_seen++;
    if (bus.out_valid && ready) delivered.push_back(bus.out_data);
    @(posedge r_clk);
    #1;
    if (fl) begin
      mbuf.delete();
    end else begin
      if (e_valid && ready) begin
        void'(mbuf.pop_front());
        mxfer++;
      end
      if (e_rinc) mbuf.push_back(fifo_q.pop_front());
    end
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    bus.rempty = 1'b0;
    bus.r_data = 8'hC3;
    fifo_q.delete();
    mbuf.delete();
    mxfer = 0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_buf_cnt", 32'(buf_cnt), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
    chk("rst_rinc_nonempty", 32'(bus.rinc), 1);
    @(posedge r_clk);
    #1;
    chk("rst_hold_buf_cnt", 32'(buf_cnt), 0);
    bus.rempty = 1'b1;
    #1;
    chk("rst_rinc_empty", 32'(bus.rinc), 0);
    @(posedge r_clk);
    #1;
    rrst_n = 1'b1;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.rempty    = 1'b1;
    bus.r_data    = '0;
    #1;
    do_reset();

    // latency: first word visible one cycle after its rinc
    fifo_q.push_back(8'h77);
    step(1'b0, 1'b0);
    chk("latency_valid", 32'(bus.out_valid), 1);
    chk("latency_data", 32'(bus.out_data), 32'h77);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // streaming 0x01..0x10
    delivered.delete();
    for (int i = 1; i <= 16; i++) fifo_q.push_back(DW'(i));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    chk("stream_count", delivered.size(), 16);
    for (int i = 0; i < delivered.size(); i++) chk("stream_word", 32'(delivered[i]), i + 1);

    // backpressure: only two words drained, head held
    delivered.delete();
    rinc_seen = 0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(8'hA0 + i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    chk("bp_rinc_pulses", rinc_seen, 2);
    chk("bp_buf_cnt", 32'(buf_cnt), 2);
    chk("bp_head", 32'(bus.out_data), 32'hA0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    chk("bp_count", delivered.size(), 5);
    for (int i = 0; i < delivered.size(); i++) chk("bp_word", 32'(delivered[i]), 32'hA0 + i);

    // empty boundary: single word
    fifo_q.push_back(8'h5A);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    chk("empty_buf_cnt", 32'(buf_cnt), 0);
    chk("empty_rinc", 32'(bus.rinc), 0);

    // flush with two words buffered and a third pending
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pre_flush_buf_cnt", 32'(buf_cnt), 2);
    delivered.delete();
    step(1'b1, 1'b0 | 1'b1);
    chk("post_flush_buf_cnt", 32'(buf_cnt), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    chk("flush_next_count", delivered.size(), 1);
    if (delivered.size() != 0) chk("flush_next_word", 32'(delivered[0]), 32'h33);

    // counter wrap: 17 transfers from reset on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) fifo_q.push_back(DW'($urandom));
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
    chk("wrap_xfer_cnt", 32'(xfer_cnt), 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) fifo_q.push_back(DW'($urandom));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end

    // reset mid-operation drops buffered words
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
